// File: rtl/bus_wait_memory.sv
// bus_wait_memory: word-organised single-port memory that responds on the
// multicycle memory bus. Every request is stalled for WAIT_CYCLES cycles
// before it is accepted. An accepted write updates the enabled byte lanes.
// An accepted read loads bus_read_data and pulses bus_valid for one cycle.
module bus_wait_memory #(
  parameter int WORDS       = 16384,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  output logic [31:0] bus_read_data,
  input  logic [31:0] bus_write_data,
  input  logic [3:0]  bus_byte_enable,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  output logic        bus_wait_req,
  output logic        bus_valid
);

  localparam int         AW       = $clog2(WORDS);
  localparam logic [3:0] WAIT_VAL = 4'(WAIT_CYCLES);

  logic [31:0]   mem_r [WORDS];
  logic [3:0]    cnt_r;
  logic [31:0]   read_data_r;
  logic          valid_r;

  logic          req_s;
  logic          wait_s;
  logic          accept_s;
  logic          write_acc_s;
  logic          read_acc_s;
  logic [AW-1:0] idx_s;
  logic          unused_s;

  // The byte offset and the address bits above the word index are not
  // decoded, so addresses alias modulo the memory size.
  assign idx_s    = bus_address[AW+1:2];
  assign unused_s = ^{bus_address[31:AW+2], bus_address[1:0]};

  // The stall is combinational, so the initiator sees it in the same cycle
  // it presents a request. Reset forces a stall, which blocks any access.
  assign req_s       = bus_read_enable | bus_write_enable;
  assign wait_s      = reset | (req_s & (cnt_r != WAIT_VAL));
  assign accept_s    = req_s & ~wait_s;
  assign write_acc_s = accept_s & bus_write_enable;
  assign read_acc_s  = accept_s & bus_read_enable & ~bus_write_enable;

  assign bus_wait_req  = wait_s;
  assign bus_read_data = read_data_r;
  assign bus_valid     = valid_r;

  // Count stall cycles of the current request. Accepting or withdrawing a
  // request restarts the count, and so does reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= 4'd0;
    end else if (!req_s) begin
      cnt_r <= 4'd0;
    end else if (accept_s) begin
      cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_r + 4'd1;
    end
  end

  // Load the read word and raise valid for exactly one cycle per accepted
  // read. The data is held until the next accepted read.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_data_r <= 32'h0000_0000;
      valid_r     <= 1'b0;
    end else if (read_acc_s) begin
      read_data_r <= mem_r[idx_s];
      valid_r     <= 1'b1;
    end else begin
      read_data_r <= read_data_r;
      valid_r     <= 1'b0;
    end
  end

  // Storage array. It is not cleared by reset. Only the enabled byte lanes
  // of an accepted write change.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (write_acc_s && bus_byte_enable[i]) begin
        mem_r[idx_s][8*i +: 8] <= bus_write_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bus_wait_memory.sv
// Directed bench for bus_wait_memory. It uses four instances with different
// depth and wait-state settings, and each instance has its own input set.
//   0: WORDS=16384 WAIT=2   1: WORDS=16 WAIT=2
//   2: WORDS=64    WAIT=3   3: WORDS=64 WAIT=0
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// on the falling edge.
module tb_bus_wait_memory;

  logic        clock;
  logic        rst   [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [3:0]  be    [4];
  logic        re    [4];
  logic        we    [4];
  logic [31:0] rdata [4];
  logic        waitr [4];
  logic        valid [4];

  int checks = 0;
  int errors = 0;

  bus_wait_memory #(.WORDS(16384), .WAIT_CYCLES(2)) dut0 (
    .clock(clock), .reset(rst[0]), .bus_address(addr[0]), .bus_read_data(rdata[0]),
    .bus_write_data(wdata[0]), .bus_byte_enable(be[0]), .bus_read_enable(re[0]),
    .bus_write_enable(we[0]), .bus_wait_req(waitr[0]), .bus_valid(valid[0]));
  bus_wait_memory #(.WORDS(16), .WAIT_CYCLES(2)) dut1 (
    .clock(clock), .reset(rst[1]), .bus_address(addr[1]), .bus_read_data(rdata[1]),
    .bus_write_data(wdata[1]), .bus_byte_enable(be[1]), .bus_read_enable(re[1]),
    .bus_write_enable(we[1]), .bus_wait_req(waitr[1]), .bus_valid(valid[1]));
  bus_wait_memory #(.WORDS(64), .WAIT_CYCLES(3)) dut2 (
    .clock(clock), .reset(rst[2]), .bus_address(addr[2]), .bus_read_data(rdata[2]),
    .bus_write_data(wdata[2]), .bus_byte_enable(be[2]), .bus_read_enable(re[2]),
    .bus_write_enable(we[2]), .bus_wait_req(waitr[2]), .bus_valid(valid[2]));
  bus_wait_memory #(.WORDS(64), .WAIT_CYCLES(0)) dut3 (
    .clock(clock), .reset(rst[3]), .bus_address(addr[3]), .bus_read_data(rdata[3]),
    .bus_write_data(wdata[3]), .bus_byte_enable(be[3]), .bus_read_enable(re[3]),
    .bus_write_enable(we[3]), .bus_wait_req(waitr[3]), .bus_valid(valid[3]));

  // Free-running clock with a period of 10 time units.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Perform one complete access on instance k. The task is called and returns
  // 1 time unit after a rising edge. It counts the stall cycles, then samples
  // valid and read data in the cycle after the accept.
  task automatic access(input int k, input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output int stalls, output logic v, output logic [31:0] rd);
    bit done;
    addr[k] = a; wdata[k] = d; be[k] = b; we[k] = w; re[k] = r;
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clock);
      if (waitr[k] === 1'b0) done = 1'b1;
      else stalls++;
      @(posedge clock); #1;
    end
    if (!done) stalls = 99;
    we[k] = 1'b0; re[k] = 1'b0;
    @(negedge clock);
    v  = valid[k];
    rd = rdata[k];
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    int s; logic v; logic [31:0] rd;
    re[0] = 1'b1; addr[0] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (waitr[0] !== 1'b1 || valid[0] !== 1'b0 || rdata[0] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs: got wait=%b valid=%b data=%h expected 1 0 00000000",
                 waitr[0], valid[0], rdata[0]);
      end
      @(posedge clock); #1;
    end
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;
    access(0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, s, v, rd);
    checks++;
    if (s !== 2 || v !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_read: got stalls=%0d valid=%b expected 2 1", s, v);
    end
  endtask

  task automatic test_write_read;
    int s; logic v; logic [31:0] rd;
    access(0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 4'hF, s, v, rd);
    checks++;
    if (s !== 2 || v !== 1'b0) begin
      errors++;
      $display("FAIL write_stall: got stalls=%0d valid=%b expected 2 0", s, v);
    end
    access(0, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0, s, v, rd);
    checks++;
    if (s !== 2 || v !== 1'b1 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_back: got stalls=%0d valid=%b data=%h expected 2 1 deadbeef", s, v, rd);
    end
    @(negedge clock);
    checks++;
    if (valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL valid_single_pulse: got %b expected 0", valid[0]);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_byte_lanes;
    int s; logic v; logic [31:0] rd;
    access(0, 1'b1, 1'b0, 32'h40, 32'h11223344, 4'b0101, s, v, rd);
    access(0, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0, s, v, rd);
    checks++;
    if (v !== 1'b1 || rd !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL byte_lanes: got valid=%b data=%h expected 1 de22be44", v, rd);
    end
    access(0, 1'b1, 1'b0, 32'h40, 32'hFFFFFFFF, 4'b0000, s, v, rd);
    checks++;
    if (s !== 2 || v !== 1'b0 || rd !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL hold_on_write: got stalls=%0d valid=%b data=%h expected 2 0 de22be44", s, v, rd);
    end
    access(0, 1'b0, 1'b1, 32'h40, 32'h0, 4'hF, s, v, rd);
    checks++;
    if (v !== 1'b1 || rd !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL be_zero: got valid=%b data=%h expected 1 de22be44", v, rd);
    end
  endtask

  task automatic test_wrap;
    int s; logic v; logic [31:0] rd;
    access(1, 1'b1, 1'b0, 32'h00000004, 32'hCAFEF00D, 4'hF, s, v, rd);
    access(1, 1'b0, 1'b1, 32'h00000047, 32'h0, 4'h0, s, v, rd);
    checks++;
    if (s !== 2 || v !== 1'b1 || rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL wrap_align: got stalls=%0d valid=%b data=%h expected 2 1 cafef00d", s, v, rd);
    end
  endtask

  task automatic test_withdraw_reset;
    int s; logic v; logic [31:0] rd;
    access(2, 1'b1, 1'b0, 32'h80, 32'h12345678, 4'hF, s, v, rd);
    checks++;
    if (s !== 3) begin
      errors++;
      $display("FAIL wait3_stall: got %0d expected 3", s);
    end
    // A write withdrawn after one stall cycle is discarded.
    addr[2] = 32'h80; wdata[2] = 32'hAAAAAAAA; be[2] = 4'hF; we[2] = 1'b1;
    @(posedge clock); #1;
    we[2] = 1'b0;
    @(posedge clock); #1;
    access(2, 1'b0, 1'b1, 32'h80, 32'h0, 4'h0, s, v, rd);
    checks++;
    if (s !== 3 || v !== 1'b1 || rd !== 32'h12345678) begin
      errors++;
      $display("FAIL withdraw: got stalls=%0d valid=%b data=%h expected 3 1 12345678", s, v, rd);
    end
    // A reset during a stalled write discards the write and clears the read data.
    wdata[2] = 32'h55555555; we[2] = 1'b1;
    @(posedge clock); #1;
    rst[2] = 1'b1;
    @(negedge clock);
    checks++;
    if (waitr[2] !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait: got %b expected 1", waitr[2]);
    end
    @(posedge clock); #1;
    rst[2] = 1'b0; we[2] = 1'b0;
    @(negedge clock);
    checks++;
    if (rdata[2] !== 32'h0 || valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL reset_clear: got data=%h valid=%b expected 00000000 0", rdata[2], valid[2]);
    end
    @(posedge clock); #1;
    access(2, 1'b0, 1'b1, 32'h80, 32'h0, 4'h0, s, v, rd);
    checks++;
    if (rd !== 32'h12345678) begin
      errors++;
      $display("FAIL reset_discard: got %h expected 12345678", rd);
    end
    // A read that is held across a reset stalls the full count again.
    re[2] = 1'b1; addr[2] = 32'h80;
    @(posedge clock); #1;
    @(posedge clock); #1;
    rst[2] = 1'b1;
    @(posedge clock); #1;
    rst[2] = 1'b0;
    access(2, 1'b0, 1'b1, 32'h80, 32'h0, 4'h0, s, v, rd);
    checks++;
    if (s !== 3 || rd !== 32'h12345678) begin
      errors++;
      $display("FAIL reset_restall: got stalls=%0d data=%h expected 3 12345678", s, rd);
    end
  endtask

  task automatic test_back_to_back;
    int s; logic v; logic [31:0] rd;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hA0A0A0A0; exp_w[1] = 32'hA1A1A1A1; exp_w[2] = 32'hA2A2A2A2;
    for (int i = 0; i < 3; i++) begin
      access(3, 1'b1, 1'b0, 32'(4 * i), exp_w[i], 4'hF, s, v, rd);
      checks++;
      if (s !== 0) begin
        errors++;
        $display("FAIL wait0_write_stall: got %0d expected 0", s);
      end
    end
    re[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) addr[3] = 32'(4 * i);
      else re[3] = 1'b0;
      @(negedge clock);
      checks++;
      if (waitr[3] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_wait: cycle %0d got %b expected 0", i, waitr[3]);
      end
      if (i > 0) begin
        checks++;
        if (valid[3] !== 1'b1 || rdata[3] !== exp_w[i-1]) begin
          errors++;
          $display("FAIL b2b_data: cycle %0d got valid=%b data=%h expected 1 %h",
                   i, valid[3], rdata[3], exp_w[i-1]);
        end
      end
      @(posedge clock); #1;
    end
    @(negedge clock);
    checks++;
    if (valid[3] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_valid_end: got %b expected 0", valid[3]);
    end
    @(posedge clock); #1;
    access(3, 1'b1, 1'b1, 32'h0, 32'hB0B0B0B0, 4'hF, s, v, rd);
    checks++;
    if (v !== 1'b0 || rd !== 32'hA2A2A2A2) begin
      errors++;
      $display("FAIL rw_priority: got valid=%b data=%h expected 0 a2a2a2a2", v, rd);
    end
    access(3, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, s, v, rd);
    checks++;
    if (v !== 1'b1 || rd !== 32'hB0B0B0B0) begin
      errors++;
      $display("FAIL rw_write_done: got valid=%b data=%h expected 1 b0b0b0b0", v, rd);
    end
  endtask

  // Sequence the scenarios and print the summary.
  initial begin
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1; addr[k] = 32'h0; wdata[k] = 32'h0; be[k] = 4'h0;
      re[k] = 1'b0; we[k] = 1'b0;
    end
    @(posedge clock); #1;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_wrap();
    test_withdraw_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
